// File: rtl/quadrature_emitter.sv
// Rotary-encoder emulator: turns step/press requests into quadrature A/B and push-switch waveforms.
// Latency: outputs registered; a step completes 2*STEP_PERIOD cycles after acceptance, a press lasts SW_PRESS_CYCLES.
// Backpressure: step_ready/press_ready drop while the matching FSM is busy; requests seen while busy are dropped.
module quadrature_emitter #(
    parameter int unsigned STEP_PERIOD     = 98304,
    parameter int unsigned SW_PRESS_CYCLES = 327680,
    parameter logic        SW_IDLE         = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_valid,
    input  logic              step_cw,
    output logic              step_ready,
    input  logic              press_valid,
    output logic              press_ready,
    output logic              enc_A,
    output logic              enc_B,
    output logic              enc_sw,
    output logic              detent,
    output logic              step_done_stb,
    output logic signed [7:0] position
);

    localparam logic [23:0] STEP_RELOAD  = 24'(STEP_PERIOD - 1);
    localparam logic [23:0] PRESS_RELOAD = 24'(SW_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MID, S_SETTLE} step_state_e;
    typedef enum logic       {P_REL, P_PRESS}          press_state_e;

    step_state_e  step_state_q, step_state_d;
    press_state_e press_state_q, press_state_d;

    logic [23:0] step_tmr_q, step_tmr_d;
    logic [23:0] press_tmr_q, press_tmr_d;
    logic [1:0]  code_q, code_d;        // {B,A}
    logic        dir_cw_q, dir_cw_d;
    logic [7:0]  pos_q, pos_d;
    logic        stb_q, stb_d;
    logic        detent_q, detent_d;
    logic        sw_q, sw_d;

    logic step_accept;
    logic press_accept;

    assign step_accept  = step_valid && (step_state_q == S_IDLE);
    assign press_accept = press_valid && (press_state_q == P_REL);

    // State and datapath registers for both FSMs
    always_ff @(posedge clk) begin
        if (reset) begin
            step_state_q  <= S_IDLE;
            press_state_q <= P_REL;
            step_tmr_q    <= '0;
            press_tmr_q   <= '0;
            code_q        <= 2'b00;
            dir_cw_q      <= 1'b0;
            pos_q         <= '0;
            stb_q         <= 1'b0;
            detent_q      <= 1'b0;
            sw_q          <= SW_IDLE;
        end else begin
            step_state_q  <= step_state_d;
            press_state_q <= press_state_d;
            step_tmr_q    <= step_tmr_d;
            press_tmr_q   <= press_tmr_d;
            code_q        <= code_d;
            dir_cw_q      <= dir_cw_d;
            pos_q         <= pos_d;
            stb_q         <= stb_d;
            detent_q      <= detent_d;
            sw_q          <= sw_d;
        end
    end

    // Step FSM next state: each phase ends when its timer reaches zero
    always_comb begin
        step_state_d = step_state_q;
        unique case (step_state_q)
            S_IDLE:   if (step_accept)        step_state_d = S_MID;
            S_MID:    if (step_tmr_q == '0)   step_state_d = S_SETTLE;
            S_SETTLE: if (step_tmr_q == '0)   step_state_d = S_IDLE;
            default:                          step_state_d = S_IDLE;
        endcase
    end

    // Step datapath: cw moves A first then B, ccw moves B first then A, so one line changes per edge
    always_comb begin
        code_d     = code_q;
        dir_cw_d   = dir_cw_q;
        step_tmr_d = step_tmr_q;
        pos_d      = pos_q;
        stb_d      = 1'b0;
        unique case (step_state_q)
            S_IDLE: begin
                if (step_accept) begin
                    dir_cw_d   = step_cw;
                    code_d     = step_cw ? (code_q ^ 2'b01) : (code_q ^ 2'b10);
                    step_tmr_d = STEP_RELOAD;
                end
            end
            S_MID: begin
                if (step_tmr_q == '0) begin
                    code_d     = dir_cw_q ? (code_q ^ 2'b10) : (code_q ^ 2'b01);
                    step_tmr_d = STEP_RELOAD;
                    pos_d      = dir_cw_q ? (pos_q + 8'd1) : (pos_q - 8'd1);
                end else begin
                    step_tmr_d = step_tmr_q - 24'd1;
                end
            end
            S_SETTLE: begin
                if (step_tmr_q == '0) begin
                    stb_d = 1'b1;
                end else begin
                    step_tmr_d = step_tmr_q - 24'd1;
                end
            end
            default: ;
        endcase
        detent_d = (code_d == 2'b11);
    end

    // Press FSM next state
    always_comb begin
        press_state_d = press_state_q;
        unique case (press_state_q)
            P_REL:   if (press_accept)       press_state_d = P_PRESS;
            P_PRESS: if (press_tmr_q == '0)  press_state_d = P_REL;
            default:                         press_state_d = P_REL;
        endcase
    end

    // Press datapath: switch level and hold timer
    always_comb begin
        sw_d        = sw_q;
        press_tmr_d = press_tmr_q;
        unique case (press_state_q)
            P_REL: begin
                if (press_accept) begin
                    sw_d        = ~SW_IDLE;
                    press_tmr_d = PRESS_RELOAD;
                end
            end
            P_PRESS: begin
                if (press_tmr_q == '0) begin
                    sw_d = SW_IDLE;
                end else begin
                    press_tmr_d = press_tmr_q - 24'd1;
                end
            end
            default: ;
        endcase
    end

    // Outputs: all from registers; ready flags decode state only
    always_comb begin
        step_ready    = (step_state_q == S_IDLE);
        press_ready   = (press_state_q == P_REL);
        enc_A         = code_q[0];
        enc_B         = code_q[1];
        enc_sw        = sw_q;
        detent        = detent_q;
        step_done_stb = stb_q;
        position      = pos_q;
    end

endmodule

// File: tb/tb_quadrature_emitter.sv
// Randomized bench for quadrature_emitter with a cycle-level reference model and scoreboard.
// Latency: expected observation for each clock edge is queued at the preceding negedge.
// Backpressure: model derives readiness from its own step/press ages, never from the DUT.
module tb_quadrature_emitter;

    localparam int P  = 4;
    localparam int SW = 6;
    localparam logic SWI = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic step_valid = 1'b0, step_cw = 1'b0, press_valid = 1'b0;
    logic step_ready, press_ready, enc_A, enc_B, enc_sw, detent, step_done_stb;
    logic signed [7:0] position;

    quadrature_emitter #(.STEP_PERIOD(P), .SW_PRESS_CYCLES(SW), .SW_IDLE(SWI)) dut (
        .clk(clk), .reset(reset),
        .step_valid(step_valid), .step_cw(step_cw), .step_ready(step_ready),
        .press_valid(press_valid), .press_ready(press_ready),
        .enc_A(enc_A), .enc_B(enc_B), .enc_sw(enc_sw), .detent(detent),
        .step_done_stb(step_done_stb), .position(position)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] code;
        logic       sw;
        logic       det;
        logic       stb;
        logic [7:0] pos;
        logic       sr;
        logic       pr;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   drv_done = 0;

    // Reference model: position in the cw gray cycle 00,01,11,10 plus ages since acceptance
    int        g = 0;
    byte       m_pos = 0;
    bit        s_busy = 0;
    int        s_age = 0;
    int        s_d = 1;
    bit        p_busy = 0;
    int        p_age = 0;
    int        steps_done = 0;

    function automatic logic [1:0] gray(input int idx);
        case (idx & 3)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic cyc(input bit rst, input bit sv, input bit cw, input bit pv);
        obs_t e;
        bit   stb;
        @(negedge clk);
        reset = rst; step_valid = sv; step_cw = cw; press_valid = pv;
        stb = 0;
        if (rst) begin
            g = 0; m_pos = 0; s_busy = 0; s_age = 0; p_busy = 0; p_age = 0;
        end else begin
            if (s_busy) begin
                s_age++;
                if (s_age == P) begin
                    g = (g + s_d) & 3;
                    m_pos = m_pos + byte'(s_d);
                end
                if (s_age == 2 * P) begin
                    s_busy = 0;
                    stb = 1;
                    steps_done++;
                end
            end else if (sv) begin
                s_busy = 1; s_age = 0; s_d = cw ? 1 : -1;
                g = (g + s_d) & 3;
            end
            if (p_busy) begin
                p_age++;
                if (p_age == SW) p_busy = 0;
            end else if (pv) begin
                p_busy = 1; p_age = 0;
            end
        end
        e.code = gray(g);
        e.sw   = p_busy ? ~SWI : SWI;
        e.det  = (gray(g) == 2'b11);
        e.stb  = stb;
        e.pos  = m_pos;
        e.sr   = !s_busy;
        e.pr   = !p_busy;
        exp_q.push_back(e);
    endtask

    // Monitor: one observation per edge, compared field by field against the queued expectation
    initial begin : monitor
        obs_t a, e;
        bit   ok;
        int   n = 0;
        while (!(drv_done && exp_q.size() == 0)) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{code: {enc_B, enc_A}, sw: enc_sw, det: detent, stb: step_done_stb,
                      pos: position, sr: step_ready, pr: press_ready};
                tests++;
                ok = 1'b1;
                if (a.code !== e.code) ok = 1'b0;
                if (a.sw   !== e.sw)   ok = 1'b0;
                if (a.det  !== e.det)  ok = 1'b0;
                if (a.stb  !== e.stb)  ok = 1'b0;
                if (a.pos  !== e.pos)  ok = 1'b0;
                if (a.sr   !== e.sr)   ok = 1'b0;
                if (a.pr   !== e.pr)   ok = 1'b0;
                if (!ok) begin
                    fails++;
                    $display("FAIL obs@%0d got BA=%b sw=%b det=%b stb=%b pos=%0d sr=%b pr=%b want BA=%b sw=%b det=%b stb=%b pos=%0d sr=%b pr=%b",
                             n, a.code, a.sw, a.det, a.stb, $signed(a.pos), a.sr, a.pr,
                             e.code, e.sw, e.det, e.stb, $signed(e.pos), e.sr, e.pr);
                end
                n++;
            end
        end
        if (fails != 0) begin
            $display("FAIL summary got %0d failures want 0", fails);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Stimulus
    initial begin : driver
        // reset state
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 1);
        cyc(0, 0, 0, 0);
        // single cw step
        cyc(0, 1, 1, 0);
        repeat (12) cyc(0, 0, 0, 0);
        // two cw then one ccw, step_valid held
        steps_done = 0;
        while (steps_done < 3) cyc(0, 1, (steps_done < 2), 0);
        repeat (3) cyc(0, 0, 0, 0);
        // press concurrent with step, extra presses while pressed
        cyc(0, 1, 1, 1);
        repeat (10) cyc(0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0);
        // reset 2 cycles into MID of a cw step
        cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 1);
        repeat (3) cyc(0, 0, 0, 0);
        // wrap: 130 cw steps from reset
        cyc(1, 0, 0, 0);
        steps_done = 0;
        while (steps_done < 130) cyc(0, 1, 1, ($urandom_range(0, 9) == 0));
        repeat (3) cyc(0, 0, 0, 0);
        // ccw across the negative wrap
        steps_done = 0;
        while (steps_done < 4) cyc(0, 1, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 9) < 6),
                $urandom_range(0, 1),
                ($urandom_range(0, 9) < 2));
        end
        repeat (4) cyc(0, 0, 0, 0);
        drv_done = 1;
    end

    // Hard stop in case the monitor never drains
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
